// File: rtl/vga_line_diff.sv
// -----------------------------------------------------------------------------
// vga_line_diff
// Streaming VGA stage: per colour channel, optionally replaces each active
// pixel with |pixel - pixel in the same column one line above|. A one-line
// RGB buffer supplies the "above" pixel. Every output bit, timing included,
// is delayed by exactly two VGA_CLK edges. Per-frame geometry status is
// reported for on-board debug.
//
// Ports
//   VGA_CLK            pixel clock, all state on rising edge
//   reset_n            asynchronous active-low reset
//   iVGA_R/G/B         incoming colours (0 while blanked)
//   iVGA_HS/VS         incoming syncs, active low
//   iVGA_SYNC_N        passthrough
//   iVGA_BLANK_N       high during active pixels
//   oVGA_*             delayed and processed bundle
//   en[2:0]            per-channel difference enable, [2]=R [1]=G [0]=B
//   line_cnt           active lines seen in the previous completed frame
//   overflow           some line of the previous frame exceeded WIDTH pixels
//   short_frame        previous frame line count differed from HEIGHT
// -----------------------------------------------------------------------------
module vga_line_diff #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                          VGA_CLK,
    input  logic                          reset_n,
    input  logic [7:0]                    iVGA_R,
    input  logic [7:0]                    iVGA_G,
    input  logic [7:0]                    iVGA_B,
    input  logic                          iVGA_HS,
    input  logic                          iVGA_VS,
    input  logic                          iVGA_SYNC_N,
    input  logic                          iVGA_BLANK_N,
    input  logic [2:0]                    en,
    output logic [7:0]                    oVGA_R,
    output logic [7:0]                    oVGA_G,
    output logic [7:0]                    oVGA_B,
    output logic                          oVGA_HS,
    output logic                          oVGA_VS,
    output logic                          oVGA_SYNC_N,
    output logic                          oVGA_BLANK_N,
    output logic [$clog2(HEIGHT+1)-1:0]   line_cnt,
    output logic                          overflow,
    output logic                          short_frame
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = $clog2(HEIGHT + 1);

    // Larger minus smaller, so the result never wraps.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    // Column / line tracking state
    logic [XW-1:0] x_q, x_d;
    logic          above_valid_q, above_valid_d;
    logic          blank_prev_q;
    logic          vs_prev_q;
    logic [LW-1:0] lines_q, lines_d;
    logic          frame_ovf_q, frame_ovf_d;

    // Status outputs
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic          overflow_q, overflow_d;
    logic          short_q, short_d;

    // Stage 1
    logic [7:0]    s1_r_q, s1_g_q, s1_b_q;
    logic          s1_hs_q, s1_vs_q, s1_sync_q, s1_blank_q;
    logic [23:0]   s1_above_q;
    logic [2:0]    s1_diff_q, s1_diff_d;

    // Stage 2
    logic [7:0]    s2_r_q, s2_g_q, s2_b_q;
    logic [7:0]    s2_r_d, s2_g_d, s2_b_d;
    logic          s2_hs_q, s2_vs_q, s2_sync_q, s2_blank_q;

    // Line buffer (contents deliberately not reset)
    logic [23:0]   line_mem [WIDTH];
    logic [AW-1:0] addr_s;
    logic          x_sat_s, wr_en_s, line_end_s, vs_first_s;

    assign x_sat_s    = (x_q == XW'(WIDTH));
    assign wr_en_s    = iVGA_BLANK_N & ~x_sat_s;
    assign line_end_s = blank_prev_q & ~iVGA_BLANK_N;
    assign vs_first_s = vs_prev_q & ~iVGA_VS;

    // Buffer address: saturated column never addresses the buffer
    always_comb begin
        addr_s = {AW{1'b0}};
        if (x_sat_s) begin
            addr_s = {AW{1'b0}};
        end else begin
            addr_s = x_q[AW-1:0];
        end
    end

    // Column counter, above-valid flag, per-frame counters and status loading
    always_comb begin
        x_d           = x_q;
        above_valid_d = above_valid_q;
        lines_d       = lines_q;
        frame_ovf_d   = frame_ovf_q;
        line_cnt_d    = line_cnt_q;
        overflow_d    = overflow_q;
        short_d       = short_q;

        if (!iVGA_BLANK_N) begin
            x_d = {XW{1'b0}};
        end else if (x_sat_s) begin
            x_d = x_q;
        end else begin
            x_d = x_q + XW'(1);
        end

        // VS low wins over a coincident line end: the new frame starts clean
        if (!iVGA_VS) begin
            above_valid_d = 1'b0;
        end else if (line_end_s) begin
            above_valid_d = 1'b1;
        end else begin
            above_valid_d = above_valid_q;
        end

        if (vs_first_s) begin
            line_cnt_d  = lines_q;
            overflow_d  = frame_ovf_q;
            short_d     = (lines_q != LW'(HEIGHT));
            // A line end on the boundary cycle belongs to the new frame
            lines_d     = line_end_s ? LW'(1) : LW'(0);
            frame_ovf_d = iVGA_BLANK_N & x_sat_s;
        end else begin
            if (line_end_s && (lines_q != {LW{1'b1}})) begin
                lines_d = lines_q + LW'(1);
            end else begin
                lines_d = lines_q;
            end
            frame_ovf_d = frame_ovf_q | (iVGA_BLANK_N & x_sat_s);
        end
    end

    // Difference select for each channel, decided as the pixel enters
    always_comb begin
        s1_diff_d = 3'b000;
        if (iVGA_BLANK_N && above_valid_q && !x_sat_s) begin
            s1_diff_d = en;
        end else begin
            s1_diff_d = 3'b000;
        end
    end

    // Stage 2 pixel operation; blank cycles force colour 0
    always_comb begin
        s2_r_d = 8'd0;
        s2_g_d = 8'd0;
        s2_b_d = 8'd0;
        if (s1_blank_q) begin
            s2_r_d = s1_diff_q[2] ? abs_diff(s1_r_q, s1_above_q[23:16]) : s1_r_q;
            s2_g_d = s1_diff_q[1] ? abs_diff(s1_g_q, s1_above_q[15:8])  : s1_g_q;
            s2_b_d = s1_diff_q[0] ? abs_diff(s1_b_q, s1_above_q[7:0])   : s1_b_q;
        end else begin
            s2_r_d = 8'd0;
            s2_g_d = 8'd0;
            s2_b_d = 8'd0;
        end
    end

    // Line buffer write; read-before-write comes from the registered read below
    always_ff @(posedge VGA_CLK) begin
        if (wr_en_s) begin
            line_mem[addr_s] <= {iVGA_R, iVGA_G, iVGA_B};
        end
    end

    // Tracking, status and both pipeline stages
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= {XW{1'b0}};
            above_valid_q <= 1'b0;
            blank_prev_q  <= 1'b0;
            vs_prev_q     <= 1'b1;
            lines_q       <= {LW{1'b0}};
            frame_ovf_q   <= 1'b0;
            line_cnt_q    <= {LW{1'b0}};
            overflow_q    <= 1'b0;
            short_q       <= 1'b0;
            s1_r_q        <= 8'd0;
            s1_g_q        <= 8'd0;
            s1_b_q        <= 8'd0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s1_sync_q     <= 1'b0;
            s1_blank_q    <= 1'b0;
            s1_above_q    <= 24'd0;
            s1_diff_q     <= 3'b000;
            s2_r_q        <= 8'd0;
            s2_g_q        <= 8'd0;
            s2_b_q        <= 8'd0;
            s2_hs_q       <= 1'b1;
            s2_vs_q       <= 1'b1;
            s2_sync_q     <= 1'b0;
            s2_blank_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            above_valid_q <= above_valid_d;
            blank_prev_q  <= iVGA_BLANK_N;
            vs_prev_q     <= iVGA_VS;
            lines_q       <= lines_d;
            frame_ovf_q   <= frame_ovf_d;
            line_cnt_q    <= line_cnt_d;
            overflow_q    <= overflow_d;
            short_q       <= short_d;
            s1_r_q        <= iVGA_R;
            s1_g_q        <= iVGA_G;
            s1_b_q        <= iVGA_B;
            s1_hs_q       <= iVGA_HS;
            s1_vs_q       <= iVGA_VS;
            s1_sync_q     <= iVGA_SYNC_N;
            s1_blank_q    <= iVGA_BLANK_N;
            s1_above_q    <= line_mem[addr_s];
            s1_diff_q     <= s1_diff_d;
            s2_r_q        <= s2_r_d;
            s2_g_q        <= s2_g_d;
            s2_b_q        <= s2_b_d;
            s2_hs_q       <= s1_hs_q;
            s2_vs_q       <= s1_vs_q;
            s2_sync_q     <= s1_sync_q;
            s2_blank_q    <= s1_blank_q;
        end
    end

    assign oVGA_R       = s2_r_q;
    assign oVGA_G       = s2_g_q;
    assign oVGA_B       = s2_b_q;
    assign oVGA_HS      = s2_hs_q;
    assign oVGA_VS      = s2_vs_q;
    assign oVGA_SYNC_N  = s2_sync_q;
    assign oVGA_BLANK_N = s2_blank_q;
    assign line_cnt     = line_cnt_q;
    assign overflow     = overflow_q;
    assign short_frame  = short_q;

endmodule

// File: tb/tb_vga_line_diff.sv
module tb_vga_line_diff;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int LW     = $clog2(HEIGHT + 1);

    logic          clk;
    logic          reset_n;
    logic [7:0]    i_r, i_g, i_b;
    logic          i_hs, i_vs, i_sync, i_blank;
    logic [2:0]    en;
    logic [7:0]    o_r, o_g, o_b;
    logic          o_hs, o_vs, o_sync, o_blank;
    logic [LW-1:0] line_cnt;
    logic          overflow, short_frame;

    vga_line_diff #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .VGA_CLK      (clk),
        .reset_n      (reset_n),
        .iVGA_R       (i_r),
        .iVGA_G       (i_g),
        .iVGA_B       (i_b),
        .iVGA_HS      (i_hs),
        .iVGA_VS      (i_vs),
        .iVGA_SYNC_N  (i_sync),
        .iVGA_BLANK_N (i_blank),
        .en           (en),
        .oVGA_R       (o_r),
        .oVGA_G       (o_g),
        .oVGA_B       (o_b),
        .oVGA_HS      (o_hs),
        .oVGA_VS      (o_vs),
        .oVGA_SYNC_N  (o_sync),
        .oVGA_BLANK_N (o_blank),
        .line_cnt     (line_cnt),
        .overflow     (overflow),
        .short_frame  (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] bundle;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Scoreboard monitor: output bundle is presented every cycle
    always @(negedge clk) begin
        if (reset_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                void'(q.pop_front());
                chk("stale_expectation", 32'd1, 32'd0);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("out_bundle", {4'd0, o_r, o_g, o_b, o_hs, o_vs, o_sync, o_blank},
                    {4'd0, e.bundle});
            end
        end
    end

    function automatic logic [63:0] px(input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [7:0] p2, input logic [7:0] p3,
                                       input logic [7:0] p4 = 8'd0,
                                       input logic [7:0] p5 = 8'd0);
        return {16'h0, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic hs, input logic vs, input logic bn,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        i_r = r; i_g = g; i_b = b; i_hs = hs; i_vs = vs; i_blank = bn; i_sync = 1'b0;
        e.bundle = {er, eg, eb, hs, vs, 1'b0, bn};
        e.due    = cyc + 2;
        q.push_back(e);
    endtask

    task automatic line(input int n, input logic [63:0] r, input logic [63:0] g,
                        input logic [63:0] b, input logic [63:0] er,
                        input logic [63:0] eg, input logic [63:0] eb);
        for (int i = 0; i < n; i++) begin
            drive(r[8*i +: 8], g[8*i +: 8], b[8*i +: 8], 1'b1, 1'b1, 1'b1,
                  er[8*i +: 8], eg[8*i +: 8], eb[8*i +: 8]);
        end
        drive(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic ramp_line(input int y);
        logic [63:0] r, g, b;
        r = '0; g = '0; b = '0;
        for (int x = 0; x < WIDTH; x++) begin
            r[8*x +: 8] = 8'(x);
            g[8*x +: 8] = 8'(y);
            b[8*x +: 8] = 8'(x + y);
        end
        line(WIDTH, r, g, b, r, g, b);
    endtask

    // Vertical sync then status check for the frame just closed
    task automatic vsync(input string tag, input int lc, input logic ov, input logic sf);
        drive(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        chk({tag, "_line_cnt"}, 32'(line_cnt), 32'(lc));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
        chk({tag, "_short"},    32'(short_frame), 32'(sf));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_bundle"}, {4'd0, o_r, o_g, o_b, o_hs, o_vs, o_sync, o_blank},
            {4'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk({tag, "_idle_status"}, {29'd0, line_cnt, overflow, short_frame}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        i_r = 8'd0; i_g = 8'd0; i_b = 8'd0;
        i_hs = 1'b1; i_vs = 1'b1; i_sync = 1'b0; i_blank = 1'b0;
        en = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset_n = 1'b1;

        // 1: passthrough ramp; reports the empty frame since reset
        vsync("t1_pre", 0, 1'b0, 1'b1);
        for (int y = 0; y < HEIGHT; y++) ramp_line(y);

        // 2: all channels differenced
        en = 3'b111;
        vsync("t2_pre", 3, 1'b0, 1'b0);
        line(4, px(10, 20, 30, 40), px(100, 50, 0, 255), px(7, 7, 7, 7),
                px(10, 20, 30, 40), px(100, 50, 0, 255), px(7, 7, 7, 7));
        line(4, px(15, 5, 30, 0), px(90, 60, 0, 0), px(0, 7, 9, 200),
                px(5, 15, 0, 40), px(10, 10, 0, 255), px(7, 0, 2, 193));
        line(4, px(15, 5, 30, 0), px(90, 60, 0, 0), px(0, 7, 9, 200),
                px(0, 0, 0, 0), px(0, 0, 0, 0), px(0, 0, 0, 0));

        // 3: red only
        en = 3'b100;
        vsync("t3_pre", 3, 1'b0, 1'b0);
        line(4, px(10, 20, 30, 40), px(100, 50, 0, 255), px(7, 7, 7, 7),
                px(10, 20, 30, 40), px(100, 50, 0, 255), px(7, 7, 7, 7));
        line(4, px(15, 5, 30, 0), px(90, 60, 0, 0), px(0, 7, 9, 200),
                px(5, 15, 0, 40), px(90, 60, 0, 0), px(0, 7, 9, 200));
        line(4, px(15, 5, 30, 0), px(90, 60, 0, 0), px(0, 7, 9, 200),
                px(0, 0, 0, 0), px(90, 60, 0, 0), px(0, 7, 9, 200));

        // 4: over-long middle line
        en = 3'b111;
        vsync("t4_pre", 3, 1'b0, 1'b0);
        line(4, px(1, 2, 3, 4), '0, '0, px(1, 2, 3, 4), '0, '0);
        line(6, px(5, 5, 5, 5, 77, 88), '0, '0, px(4, 3, 2, 1, 77, 88), '0, '0);
        line(4, px(1, 1, 1, 1), '0, '0, px(4, 4, 4, 4), '0, '0);

        // 5: short frame then a normal one
        en = 3'b000;
        vsync("t4_post", 3, 1'b1, 1'b0);
        ramp_line(0);
        ramp_line(1);
        vsync("t5_short", 2, 1'b0, 1'b1);
        for (int y = 0; y < HEIGHT; y++) ramp_line(y);
        vsync("t5_normal", 3, 1'b0, 1'b0);

        // 6: asynchronous reset in the middle of line 1
        en = 3'b111;
        line(4, px(10, 20, 30, 40), '0, '0, px(10, 20, 30, 40), '0, '0);
        drive(8'd15, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd5, 8'd0, 8'd0);
        drive(8'd5, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd15, 8'd0, 8'd0);
        drive(8'd30, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
        #2;
        chk("t6_pre_reset_r", 32'(o_r), 32'd5);
        reset_n = 1'b0;
        #1;
        chk_idle("t6_async");
        q.delete();
        i_r = 8'd0; i_g = 8'd0; i_b = 8'd0;
        i_hs = 1'b1; i_vs = 1'b1; i_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        line(4, px(10, 20, 30, 40), px(9, 9, 9, 9), px(1, 2, 3, 4),
                px(10, 20, 30, 40), px(9, 9, 9, 9), px(1, 2, 3, 4));
        line(4, px(15, 5, 30, 0), px(9, 0, 20, 9), px(4, 3, 2, 1),
                px(5, 15, 0, 40), px(0, 9, 11, 0), px(3, 1, 1, 3));
        vsync("t6_post", 2, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            drive(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_line_diff.md
Name: vga_line_diff

Overview:
- Streaming VGA stage directly downstream of the horizontal-difference filter stage, with the same 28-bit VGA bundle in and out.
- Per channel, it optionally replaces each active pixel with the absolute difference between that pixel and the pixel in the same column one line above.
- Holds one line of RGB in an internal line buffer; all timing signals are delayed to match the pixel path.
- Also reports per-frame geometry status (lines seen, line overflow) for on-board debug.

Parameters:
- WIDTH, 640, maximum active pixels per line; line buffer depth.
- HEIGHT, 480, nominal active lines per frame; used only for status width and the short-frame flag.

Ports:
- VGA_CLK  in  1  pixel clock, 25 MHz; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- iVGA_R, iVGA_G, iVGA_B  in  8 each  incoming colours; 0 while iVGA_BLANK_N low.
- iVGA_HS  in  1  horizontal sync, active low.
- iVGA_VS  in  1  vertical sync, active low.
- iVGA_SYNC_N  in  1  passthrough, always 0.
- iVGA_BLANK_N  in  1  high during active pixels.
- oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N  out  8/8/8/1/1/1/1  delayed and processed bundle.
- en  in  3  per-channel enable: [2]=R, [1]=G, [0]=B; 0 means pass the channel through unmodified.
- line_cnt  out  clog2(HEIGHT+1)  active lines counted in the previous completed frame.
- overflow  out  1  sticky: some line in the previous frame exceeded WIDTH active pixels.
- short_frame  out  1  previous frame had line_cnt != HEIGHT.

Behaviour:
- Reset (async assert, sync release on the next edge):
  - oVGA_R/G/B = 0, oVGA_HS = 1, oVGA_VS = 1, oVGA_SYNC_N = 0, oVGA_BLANK_N = 0.
  - line_cnt = 0, overflow = 0, short_frame = 0.
  - Column counter x = 0, above_valid = 0, internal pipeline registers cleared to the same idle values.
  - Line buffer contents are not reset.
- Latency: exactly 2 VGA_CLK edges for every output bit, including during blanking.
  - Stage 1 registers the input bundle plus the line-buffer read data at address x.
  - Stage 2 registers the final output.
- Line buffer: WIDTH x 24 bits, one read and one write per active cycle at the same address x.
  - Read returns the OLD data, i.e. the previous line's pixel; read-before-write.
- Column counter x:
  - Increments on each input cycle with iVGA_BLANK_N = 1.
  - Cleared on any cycle with iVGA_BLANK_N = 0.
  - Saturates at WIDTH.
  - When x = WIDTH on an active cycle: no write, the pixel passes through unmodified, and the internal frame-overflow flag is set.
- Line tracking:
  - Falling edge of iVGA_BLANK_N (active to blank) increments the frame line counter and sets above_valid = 1.
  - iVGA_VS = 0 clears above_valid and arms a frame boundary.
  - On the first VS-low cycle of each sync pulse, line_cnt, overflow and short_frame load from the internal counters.
  - The same cycle clears the internal counters; a simultaneous line-end on that cycle counts toward the new frame.
- Pixel op, per channel c, at stage 2:
  - If the stage-1 BLANK_N = 1, en[c] = 1 and above_valid was 1 when the pixel entered: out = |cur - above|, 8-bit unsigned, computed as larger minus smaller, no wrap.
  - Otherwise out = cur.
  - Blank cycles always output colour 0.
- First line of each frame is passed through unmodified on all channels.
- en is sampled in stage 1; a change mid-line takes effect on the next input pixel.
- Reset asserted mid-frame returns all outputs to reset values immediately.
  - After release, the first frame's first line is passthrough, because above_valid = 0.

Test Plan:
1. WIDTH=4, HEIGHT=3, en=3'b000, ramp R=x, G=y, B=x+y -> output equals input delayed exactly 2 cycles, including HS/VS/BLANK_N edges.
2. en=3'b111, line0 R=(10,20,30,40), line1 R=(15,5,30,0) -> line0 out (10,20,30,40) unmodified; line1 out (5,15,0,40); G and B behave likewise.
3. en=3'b100 only, same stimulus -> R differenced; G and B bit-identical to input delayed by 2 cycles.
4. Frame of 3 lines, one with 6 active pixels -> at next VS: line_cnt=3, overflow=1, short_frame=0; pixels 5-6 of that line pass through unchanged.
5. Frame with only 2 active lines -> line_cnt=2, short_frame=1; the following normal frame clears it to 0.
6. Assert reset_n=0 mid-line 1 for 3 cycles, asynchronous to the clock -> outputs go to idle values without waiting for an edge; after release, the next frame's line 0 is passthrough and line 1 is differenced correctly.
